// File: rtl/xc_fsr_seq.sv
// Funnel-shift / rotate sequencer: a 64-bit window W is rotated right in six
// power-of-two stages (32,16,8,4,2,1), and the result is the upper half of W.
module xc_fsr_seq #(
    parameter int FAST_ZERO = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_w;
    logic [63:0] w_w_next;
    logic [2:0]  r_stage;
    logic [2:0]  w_stage_next;
    logic [5:0]  r_amt;
    logic [5:0]  w_amt_next;
    logic [1:0]  r_op;
    logic [1:0]  w_op_next;

    logic        w_accept;
    logic [5:0]  w_req_amt;
    logic [6:0]  w_shamt;
    logic [63:0] w_rot;
    logic        w_unused_ok;

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign rsp_result = (r_state == DONE) ? r_w[63:32] : 32'd0;

    // A request arriving together with flush is dropped.
    assign w_accept = req_valid & req_ready & ~flush;

    // Left forms become right rotations by the complementary amount (mod 64).
    assign w_req_amt = req_op[0] ? (6'd0 - req_rs2[5:0]) : req_rs2[5:0];

    assign w_shamt = 7'd1 << r_stage;
    assign w_rot   = (r_w >> w_shamt) | (r_w << (7'd64 - w_shamt));

    assign w_unused_ok = ^{req_rs2[31:6], r_op};

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_w_next     = r_w;
        w_stage_next = r_stage;
        w_amt_next   = r_amt;
        w_op_next    = r_op;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_w_next     = {req_rs1, req_op[1] ? req_rs1 : req_rs3};
                    w_stage_next = 3'd5;
                    w_amt_next   = w_req_amt;
                    w_op_next    = req_op;
                    if ((w_req_amt == 6'd0) && (FAST_ZERO != 0)) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_amt[r_stage]) begin
                    w_w_next = w_rot;
                end
                if (r_stage == 3'd0) begin
                    w_state_next = DONE;
                end else begin
                    w_stage_next = r_stage - 3'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (flush) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_w     <= 64'd0;
            r_stage <= 3'd0;
            r_amt   <= 6'd0;
            r_op    <= 2'd0;
        end else begin
            r_w     <= w_w_next;
            r_stage <= w_stage_next;
            r_amt   <= w_amt_next;
            r_op    <= w_op_next;
        end
    end

endmodule
